// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the I2C command arbiter slice.
package i2c_arb_pkg;

    localparam int unsigned TMO_W    = 20;
    localparam int unsigned TO_CNT_W = 4;
    localparam int unsigned SKIP_W   = 3;
    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned ST_W     = 3;

    // Arbiter state encoding
    typedef logic [ST_W-1:0] arb_state_t;
    localparam arb_state_t ST_IDLE  = 3'd0;
    localparam arb_state_t ST_GRANT = 3'd1;
    localparam arb_state_t ST_RUN   = 3'd2;
    localparam arb_state_t ST_DONE  = 3'd3;
    localparam arb_state_t ST_ABORT = 3'd4;

    localparam logic OWN_HOST  = 1'b0;
    localparam logic OWN_SCHED = 1'b1;

endpackage

// File: rtl/i2c_arb_wdog.sv
// Transaction watchdog: counts RUN cycles and flags the last cycle before timeout.
module i2c_arb_wdog
    import i2c_arb_pkg::*;
#(
    parameter logic [TMO_W-1:0] TIMEOUT_CYC = 20'd400000
)(
    input  logic CLK40,
    input  logic rst_fifo,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc_c
);

    logic [TMO_W-1:0] r_cnt;

    always_ff @(posedge CLK40 or posedge rst_fifo) begin
        if (rst_fifo) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_tc_c) begin
            r_cnt <= r_cnt + TMO_W'(1);
        end
    end

    assign o_tc_c = (r_cnt == TIMEOUT_CYC - TMO_W'(1));

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// Shares the I2C command parser between the JTAG host FIFO and the refresh scheduler,
// with per-transaction watchdog and stale-request protection.
module i2c_cmd_arbiter
    import i2c_arb_pkg::*;
#(
    parameter logic [TMO_W-1:0] TIMEOUT_CYC = 20'd400000,
    parameter bit               HOST_PRIO   = 1'b1,
    parameter int unsigned      SKIP_MAX    = 4
)(
    input  logic                CLK40,
    input  logic                rst_fifo,
    input  logic                HOST_REQ,
    input  logic [BYTE_W-1:0]   HOST_DATA,
    input  logic                HOST_MT,
    output logic                HOST_POP,
    output logic                HOST_GNT,
    output logic                HOST_DONE,
    input  logic                SCHED_REQ,
    input  logic [BYTE_W-1:0]   SCHED_DATA,
    input  logic                SCHED_MT,
    output logic                SCHED_POP,
    output logic                SCHED_GNT,
    output logic                SCHED_DONE,
    output logic                PRS_START,
    output logic [BYTE_W-1:0]   PRS_DATA,
    output logic                PRS_MT,
    input  logic                PRS_READ_FF,
    input  logic                PRS_DONE,
    output logic                BUSY,
    output logic                OWNER,
    output logic                TO_PULSE,
    output logic [TO_CNT_W-1:0] TO_CNT
);

    arb_state_t          r_state, w_state_nxt;
    logic                r_owner, w_owner_nxt;
    logic                r_last_owner, w_last_nxt;
    logic                r_host_gnt, w_host_gnt_nxt;
    logic                r_sched_gnt, w_sched_gnt_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_start, w_start_nxt;
    logic                r_host_done, w_host_done_nxt;
    logic                r_sched_done, w_sched_done_nxt;
    logic                r_to_pulse, w_to_pulse_nxt;
    logic [TO_CNT_W-1:0] r_to_cnt, w_to_cnt_nxt;
    logic [SKIP_W-1:0]   r_skip, w_skip_nxt;
    logic                r_host_armed, w_host_armed_nxt;
    logic                r_sched_armed, w_sched_armed_nxt;

    logic w_host_elig, w_sched_elig, w_win, w_disarm;
    logic w_wd_clr, w_wd_en, w_wd_tc, w_gnt;

    i2c_arb_wdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wdog (
        .CLK40    (CLK40),
        .rst_fifo (rst_fifo),
        .i_clr    (w_wd_clr),
        .i_en     (w_wd_en),
        .o_tc_c   (w_wd_tc)
    );

    assign w_host_elig  = HOST_REQ  & ~HOST_MT  & r_host_armed;
    assign w_sched_elig = SCHED_REQ & ~SCHED_MT & r_sched_armed;

    // Tie-break between two eligible requesters
    always_comb begin
        w_win = OWN_HOST;
        if (w_host_elig && w_sched_elig) begin
            if (HOST_PRIO) begin
                w_win = (r_skip >= SKIP_W'(SKIP_MAX)) ? OWN_SCHED : OWN_HOST;
            end else begin
                w_win = ~r_last_owner;
            end
        end else if (w_sched_elig) begin
            w_win = OWN_SCHED;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_last_nxt       = r_last_owner;
        w_host_gnt_nxt   = r_host_gnt;
        w_sched_gnt_nxt  = r_sched_gnt;
        w_busy_nxt       = r_busy;
        w_start_nxt      = 1'b0;
        w_host_done_nxt  = 1'b0;
        w_sched_done_nxt = 1'b0;
        w_to_pulse_nxt   = 1'b0;
        w_to_cnt_nxt     = r_to_cnt;
        w_skip_nxt       = r_skip;
        w_disarm         = 1'b0;
        w_wd_clr         = 1'b1;
        w_wd_en          = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_host_elig || w_sched_elig) begin
                    w_state_nxt     = ST_GRANT;
                    w_owner_nxt     = w_win;
                    w_host_gnt_nxt  = (w_win == OWN_HOST);
                    w_sched_gnt_nxt = (w_win == OWN_SCHED);
                    w_busy_nxt      = 1'b1;
                    if (w_win == OWN_SCHED) begin
                        w_skip_nxt = '0;
                    end else if (w_sched_elig && (r_skip != '1)) begin
                        w_skip_nxt = r_skip + SKIP_W'(1);
                    end
                end
            end
            ST_GRANT: begin
                w_state_nxt = ST_RUN;
                w_start_nxt = 1'b1;
            end
            ST_RUN: begin
                w_wd_clr    = 1'b0;
                w_wd_en     = 1'b1;
                w_start_nxt = 1'b1;
                if (PRS_DONE) begin
                    w_state_nxt = ST_DONE;
                    w_start_nxt = 1'b0;
                end else if (w_wd_tc) begin
                    // Timeout is reported on the terminal edge itself
                    w_state_nxt      = ST_ABORT;
                    w_start_nxt      = 1'b0;
                    w_to_pulse_nxt   = 1'b1;
                    w_host_done_nxt  = (r_owner == OWN_HOST);
                    w_sched_done_nxt = (r_owner == OWN_SCHED);
                    if (r_to_cnt != '1) begin
                        w_to_cnt_nxt = r_to_cnt + TO_CNT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt      = ST_IDLE;
                w_host_gnt_nxt   = 1'b0;
                w_sched_gnt_nxt  = 1'b0;
                w_busy_nxt       = 1'b0;
                w_host_done_nxt  = (r_owner == OWN_HOST);
                w_sched_done_nxt = (r_owner == OWN_SCHED);
                w_last_nxt       = r_owner;
                w_disarm         = 1'b1;
            end
            ST_ABORT: begin
                w_state_nxt     = ST_IDLE;
                w_host_gnt_nxt  = 1'b0;
                w_sched_gnt_nxt = 1'b0;
                w_busy_nxt      = 1'b0;
                w_disarm        = 1'b1;
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_host_gnt_nxt  = 1'b0;
                w_sched_gnt_nxt = 1'b0;
                w_busy_nxt      = 1'b0;
            end
        endcase

        // REQ seen low re-arms, even on the edge that ends the owner's transaction
        w_host_armed_nxt  = ~HOST_REQ  | (r_host_armed  & ~(w_disarm & (r_owner == OWN_HOST)));
        w_sched_armed_nxt = ~SCHED_REQ | (r_sched_armed & ~(w_disarm & (r_owner == OWN_SCHED)));
    end

    always_ff @(posedge CLK40 or posedge rst_fifo) begin
        if (rst_fifo) begin
            r_state       <= ST_IDLE;
            r_owner       <= OWN_HOST;
            r_last_owner  <= OWN_SCHED;
            r_host_gnt    <= 1'b0;
            r_sched_gnt   <= 1'b0;
            r_busy        <= 1'b0;
            r_start       <= 1'b0;
            r_host_done   <= 1'b0;
            r_sched_done  <= 1'b0;
            r_to_pulse    <= 1'b0;
            r_to_cnt      <= '0;
            r_skip        <= '0;
            r_host_armed  <= 1'b1;
            r_sched_armed <= 1'b1;
        end else begin
            r_state       <= w_state_nxt;
            r_owner       <= w_owner_nxt;
            r_last_owner  <= w_last_nxt;
            r_host_gnt    <= w_host_gnt_nxt;
            r_sched_gnt   <= w_sched_gnt_nxt;
            r_busy        <= w_busy_nxt;
            r_start       <= w_start_nxt;
            r_host_done   <= w_host_done_nxt;
            r_sched_done  <= w_sched_done_nxt;
            r_to_pulse    <= w_to_pulse_nxt;
            r_to_cnt      <= w_to_cnt_nxt;
            r_skip        <= w_skip_nxt;
            r_host_armed  <= w_host_armed_nxt;
            r_sched_armed <= w_sched_armed_nxt;
        end
    end

    assign w_gnt = r_host_gnt | r_sched_gnt;

    // Parser-side byte stream follows the granted owner with no added latency
    always_comb begin
        PRS_DATA  = '0;
        PRS_MT    = 1'b1;
        HOST_POP  = 1'b0;
        SCHED_POP = 1'b0;
        if (w_gnt) begin
            if (r_owner == OWN_SCHED) begin
                PRS_DATA  = SCHED_DATA;
                PRS_MT    = SCHED_MT;
                SCHED_POP = PRS_READ_FF;
            end else begin
                PRS_DATA  = HOST_DATA;
                PRS_MT    = HOST_MT;
                HOST_POP  = PRS_READ_FF;
            end
        end
    end

    assign HOST_GNT   = r_host_gnt;
    assign SCHED_GNT  = r_sched_gnt;
    assign HOST_DONE  = r_host_done;
    assign SCHED_DONE = r_sched_done;
    assign PRS_START  = r_start;
    assign BUSY       = r_busy;
    assign OWNER      = r_owner;
    assign TO_PULSE   = r_to_pulse;
    assign TO_CNT     = r_to_cnt;

endmodule
